counter_ctrl: RTL and testbench

Run-control and configuration controller for a shared up-counter datapath of the 4-bit counter family. Owns the count register. Adds a programmable terminal value, a clock prescaler, one-shot or periodic mode, start/stop control, and a one-cycle terminal-count pulse. It sits between a control master, which issues cfg/start/stop, and consumers of count/tc such as timers, sequencers and pulse generators.

---
 rtl/counter_ctrl.sv | 100 ++++++++++
 tb/tb_counter_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// Run-control and configuration controller for a shared up-counter: owns the count
// register and provides a programmable terminal value, a prescaler, one-shot/periodic modes and a tc pulse.
module counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [WIDTH-1:0]   cfg_term,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               cfg_oneshot,
  input  logic               start,
  input  logic               stop,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tc
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic               tc_q, tc_d;
  logic [WIDTH-1:0]   term_q, term_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               oneshot_q, oneshot_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      presc_cnt_q <= '0;
      tc_q        <= 1'b0;
      term_q      <= '1;
      presc_q     <= '0;
      oneshot_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
      tc_q        <= tc_d;
      term_q      <= term_d;
      presc_q     <= presc_d;
      oneshot_q   <= oneshot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_cnt_d = presc_cnt_q;
    tc_d        = 1'b0;
    term_d      = term_q;
    presc_d     = presc_q;
    oneshot_d   = oneshot_q;

    // Config is only taken while idle, so a run never sees its parameters change.
    if (cfg_valid && (state_q == IDLE)) begin
      term_d    = cfg_term;
      presc_d   = cfg_presc;
      oneshot_d = cfg_oneshot;
    end

    if (stop) begin
      if (state_q == RUN) begin
        state_d     = IDLE;
        presc_cnt_d = '0;
      end
    end else if (start) begin
      state_d     = RUN;
      count_d     = '0;
      presc_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (presc_cnt_q != presc_q) begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end else begin
        presc_cnt_d = '0;
        if (count_q != term_q) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          tc_d    = 1'b1;
          if (oneshot_q) state_d = IDLE;
        end
      end
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == RUN);
  assign cfg_ready = (state_q == IDLE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus queues the hand-derived post-edge outputs,
// and a monitor pops and compares them one cycle at a time.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_term = 4'd0;
  logic [3:0] cfg_presc = 4'd0;
  logic       cfg_oneshot = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       tc;

  typedef struct {
    logic [3:0] cnt;
    logic       busy;
    logic       tc;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  counter_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_term   (cfg_term),
    .cfg_presc  (cfg_presc),
    .cfg_oneshot(cfg_oneshot),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .tc         (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1);
  end

  // Monitor: one expected record per clock edge, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (count !== e.cnt || busy !== e.busy || tc !== e.tc || cfg_ready !== e.rdy) begin
          errors++;
          $display("FAIL %s: got count=%0d busy=%0b tc=%0b cfg_ready=%0b, expected count=%0d busy=%0b tc=%0b cfg_ready=%0b",
                   e.nm, count, busy, tc, cfg_ready, e.cnt, e.busy, e.tc, e.rdy);
        end else begin
          $display("ok   %s: count=%0d busy=%0b tc=%0b cfg_ready=%0b", e.nm, count, busy, tc, cfg_ready);
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic p, input logic cv,
                     input logic [3:0] ec, input logic eb, input logic et, input logic er,
                     input string nm);
    exp_t e;
    start     = s;
    stop      = p;
    cfg_valid = cv;
    e.cnt = ec; e.busy = eb; e.tc = et; e.rdy = er; e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] t, input logic [3:0] p, input logic os);
    cfg_term    = t;
    cfg_presc   = p;
    cfg_oneshot = os;
  endtask

  initial begin
    // Scenario 1: reset, then free-running default counter.
    rst = 1'b1;
    cyc(0, 0, 0, 4'd0, 0, 0, 1, "reset0");
    cyc(0, 0, 0, 4'd0, 0, 0, 1, "reset1");
    rst = 1'b0;
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s1_start");
    for (int k = 1; k <= 32; k++)
      cyc(0, 0, 0, 4'(k % 16), 1, (k % 16) == 0, 0, $sformatf("s1_k%0d", k));
    cyc(0, 1, 0, 4'd0, 0, 0, 1, "s1_stop");

    // Scenario 2: term=5 presc=2 one-shot.
    set_cfg(4'd5, 4'd2, 1'b1);
    cyc(0, 0, 1, 4'd0, 0, 0, 1, "s2_cfg");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s2_start");
    for (int k = 1; k <= 17; k++)
      cyc(0, 0, 0, 4'(k / 3), 1, 0, 0, $sformatf("s2_k%0d", k));
    cyc(0, 0, 0, 4'd0, 0, 1, 1, "s2_terminal");
    for (int k = 0; k < 5; k++)
      cyc(0, 0, 0, 4'd0, 0, 0, 1, $sformatf("s2_after%0d", k));

    // Scenario 3: defaults, stop after 7 cycles, restart from 0.
    set_cfg(4'd15, 4'd0, 1'b0);
    cyc(0, 0, 1, 4'd0, 0, 0, 1, "s3_cfg");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s3_start");
    for (int k = 1; k <= 7; k++)
      cyc(0, 0, 0, 4'(k), 1, 0, 0, $sformatf("s3_k%0d", k));
    cyc(0, 1, 0, 4'd7, 0, 0, 1, "s3_stop");
    cyc(0, 0, 0, 4'd7, 0, 0, 1, "s3_frozen0");
    cyc(0, 0, 0, 4'd7, 0, 0, 1, "s3_frozen1");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s3_restart");
    cyc(0, 0, 0, 4'd1, 1, 0, 0, "s3_restart_k1");

    // Scenario 4: term=0 presc=3 periodic, config+start together; cfg in RUN must be ignored.
    cyc(0, 1, 0, 4'd1, 0, 0, 1, "s4_stop_prev");
    set_cfg(4'd0, 4'd3, 1'b0);
    cyc(1, 0, 1, 4'd0, 1, 0, 0, "s4_cfg_start");
    for (int k = 1; k <= 12; k++) begin
      if (k >= 5 && k <= 8) set_cfg(4'd9, 4'd0, 1'b1);
      cyc(0, 0, (k >= 5 && k <= 8), 4'd0, 1, (k % 4) == 0, 0, $sformatf("s4_k%0d", k));
    end
    cyc(0, 1, 0, 4'd0, 0, 0, 1, "s4_stop");

    // Scenario 5: term=3 presc=0, stop on the terminal cycle, then stop+start.
    set_cfg(4'd3, 4'd0, 1'b0);
    cyc(0, 0, 1, 4'd0, 0, 0, 1, "s5_cfg");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s5_start");
    for (int k = 1; k <= 3; k++)
      cyc(0, 0, 0, 4'(k), 1, 0, 0, $sformatf("s5_k%0d", k));
    cyc(0, 1, 0, 4'd3, 0, 0, 1, "s5_stop_terminal");
    cyc(0, 0, 0, 4'd3, 0, 0, 1, "s5_idle0");
    cyc(0, 0, 0, 4'd3, 0, 0, 1, "s5_idle1");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s5_start2");
    cyc(0, 0, 0, 4'd1, 1, 0, 0, "s5_k1b");
    cyc(1, 1, 0, 4'd1, 0, 0, 1, "s5_stop_start_run");
    cyc(1, 1, 0, 4'd1, 0, 0, 1, "s5_stop_start_idle");

    // Scenario 6: term=12, reset at count 9 restores default config.
    set_cfg(4'd12, 4'd0, 1'b0);
    cyc(0, 0, 1, 4'd1, 0, 0, 1, "s6_cfg");
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s6_start");
    for (int k = 1; k <= 9; k++)
      cyc(0, 0, 0, 4'(k), 1, 0, 0, $sformatf("s6_k%0d", k));
    rst = 1'b1;
    cyc(0, 0, 0, 4'd0, 0, 0, 1, "s6_rst");
    rst = 1'b0;
    cyc(1, 0, 0, 4'd0, 1, 0, 0, "s6_start_after_rst");
    for (int k = 1; k <= 16; k++)
      cyc(0, 0, 0, 4'(k % 16), 1, (k % 16) == 0, 0, $sformatf("s6_k%0db", k));
    cyc(0, 1, 0, 4'd0, 0, 0, 1, "s6_stop");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
